// File: rtl/option_queue_sequencer.sv
// Circular queue of line headers and candidate options, replayed to a line solver
// until a full pass removes nothing. Kept options are re-enqueued, rejected ones dropped.
module option_queue_sequencer #(
  parameter int SIZE  = 3,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  input  logic                     load_is_line,
  input  logic [SIZE-1:0]          load_data,
  output logic                     load_ready,
  input  logic                     start,
  output logic [SIZE-1:0]          option,
  output logic                     valid_op,
  input  logic                     solver_valid_out,
  input  logic                     put_back_to_FIFO,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     done,
  output logic                     solved,
  output logic                     overflow
);

  // state | meaning
  // LOAD  | accepting entries from the loader
  // ISSUE | head entry presented to the solver this cycle
  // GAP   | idle cycle after a header so the solver can switch lines
  // WAIT  | holding an option until the solver returns its verdict
  // DONE  | pass finished with no removals; absorbing until reset
  localparam logic [2:0] LOAD  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] SOLVE_CNT = CW'(4 * SIZE);

  logic [SIZE:0]     mem_q [DEPTH];
  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d, pass_q, pass_d, removed_q, removed_d;
  logic [SIZE-1:0]   hold_q, hold_d;
  logic              done_q, done_d, solved_q, solved_d, overflow_q, overflow_d;
  logic              wr_en, pass_end;
  logic [SIZE:0]     wr_data, head;

  assign head       = mem_q[rd_q];
  assign load_ready = (state_q == LOAD) && (count_q != FULL);
  assign valid_op   = (state_q == ISSUE);
  assign option     = (state_q == ISSUE) ? head[SIZE-1:0] : '0;
  assign count      = count_q;
  assign done       = done_q;
  assign solved     = solved_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    pass_d     = pass_q;
    removed_d  = removed_q;
    hold_d     = hold_q;
    done_d     = done_q;
    solved_d   = solved_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_data    = '0;
    pass_end   = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_valid) begin
          if (count_q != FULL) begin
            wr_en   = 1'b1;
            wr_data = {load_is_line, load_data};
            wr_d    = wr_q + AW'(1);
            count_d = count_q + CW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (start) begin
          if (count_d == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = ISSUE;
            pass_d    = count_d;
            removed_d = '0;
          end
        end
      end
      ISSUE: begin
        rd_d   = rd_q + AW'(1);
        pass_d = pass_q - CW'(1);
        if (head[SIZE]) begin
          wr_en   = 1'b1;
          wr_data = head;
          wr_d    = wr_q + AW'(1);
          state_d = GAP;
        end else begin
          hold_d  = head[SIZE-1:0];
          count_d = count_q - CW'(1);
          state_d = WAIT;
        end
      end
      GAP:  pass_end = 1'b1;
      WAIT: begin
        if (solver_valid_out) begin
          if (put_back_to_FIFO) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, hold_q};
            wr_d    = wr_q + AW'(1);
            count_d = count_q + CW'(1);
          end else begin
            removed_d = removed_q + CW'(1);
          end
          pass_end = 1'b1;
        end
      end
      default: ;
    endcase

    if (pass_end) begin
      if (pass_q != '0) begin
        state_d = ISSUE;
      // An emptied queue (no headers left) cannot be replayed, so it also terminates.
      end else if (removed_d == '0 || count_d == '0) begin
        state_d  = DONE;
        done_d   = 1'b1;
        solved_d = (count_d == SOLVE_CNT);
      end else begin
        state_d   = ISSUE;
        pass_d    = count_d;
        removed_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      pass_q     <= '0;
      removed_q  <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      solved_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      pass_q     <= pass_d;
      removed_q  <= removed_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      solved_q   <= solved_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_option_queue_sequencer.sv
// Bench for option_queue_sequencer: scoreboard of expected solver issues with a
// responding solver model, plus a vector table for the small-depth overflow case.
module tb_option_queue_sequencer;
  localparam int SIZE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            load_valid, load_is_line, load_ready, start;
  logic [SIZE-1:0] load_data, option;
  logic            valid_op, solver_valid_out, put_back_to_FIFO;
  logic [6:0]      count;
  logic            done, solved, overflow;

  logic            b_load_valid, b_load_is_line, b_load_ready, b_start;
  logic [SIZE-1:0] b_load_data, b_option;
  logic            b_valid_op;
  logic [2:0]      b_count;
  logic            b_done, b_solved, b_overflow;

  option_queue_sequencer #(.SIZE(SIZE), .DEPTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_is_line(load_is_line),
    .load_data(load_data), .load_ready(load_ready), .start(start), .option(option),
    .valid_op(valid_op), .solver_valid_out(solver_valid_out),
    .put_back_to_FIFO(put_back_to_FIFO), .count(count), .done(done), .solved(solved),
    .overflow(overflow));

  option_queue_sequencer #(.SIZE(SIZE), .DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .load_valid(b_load_valid), .load_is_line(b_load_is_line),
    .load_data(b_load_data), .load_ready(b_load_ready), .start(b_start), .option(b_option),
    .valid_op(b_valid_op), .solver_valid_out(solver_valid_out),
    .put_back_to_FIFO(put_back_to_FIFO), .count(b_count), .done(b_done), .solved(b_solved),
    .overflow(b_overflow));

  typedef struct {logic is_line; logic [SIZE-1:0] data; logic keep;} exp_t;
  typedef struct {logic lv; logic il; logic [SIZE-1:0] d; logic exp_ready; int exp_count; logic exp_ovf;} vec_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   resp_en = 1'b1;

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Solver model and scoreboard: compares each issued option, answers options after 0..2 cycles.
  bit   resp_pending = 1'b0;
  bit   resp_keep = 1'b0;
  int   resp_delay = 0;
  int   cyc = 0, last_cyc = 0;
  bit   last_hdr = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    solver_valid_out = 1'b0;
    put_back_to_FIFO = 1'b0;
    if (!rst_n) begin
      resp_pending = 1'b0;
      last_hdr = 1'b0;
    end else begin
      if (resp_pending) begin
        if (resp_delay == 0) begin
          solver_valid_out = 1'b1;
          put_back_to_FIFO = resp_keep;
          resp_pending = 1'b0;
        end else resp_delay--;
      end
      if (valid_op) begin
        if (exp_q.size() == 0) check("unexpected_valid_op", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("option", option, e.data);
          if (last_hdr) check("gap_after_header", int'(cyc - last_cyc >= 2), 1);
          last_hdr = e.is_line;
          last_cyc = cyc;
          if (!e.is_line && resp_en) begin
            resp_pending = 1'b1;
            resp_keep = e.keep;
            resp_delay = $urandom_range(0, 2);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    load_valid = 0; load_is_line = 0; load_data = '0; start = 0;
    b_load_valid = 0; b_load_is_line = 0; b_load_data = '0; b_start = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load(logic il, logic [SIZE-1:0] d);
    load_valid = 1'b1; load_is_line = il; load_data = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic push_exp(logic il, logic [SIZE-1:0] d, logic keep);
    exp_t x;
    x.is_line = il; x.data = d; x.keep = keep;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done"}, done, 1);
    repeat (4) @(negedge clk);
    check({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    for (int k = 0; k < 5; k++) begin
      tbl[k].lv = 1'b1; tbl[k].il = (k == 0); tbl[k].d = SIZE'(k);
      tbl[k].exp_ready = (k < 4); tbl[k].exp_count = (k < 4) ? k + 1 : 4;
      tbl[k].exp_ovf = (k == 4);
    end
    tbl[5].lv = 1'b0; tbl[5].il = 1'b0; tbl[5].d = '0;
    tbl[5].exp_ready = 1'b0; tbl[5].exp_count = 4; tbl[5].exp_ovf = 1'b1;

    do_reset();
    check("rst_count", count, 0);
    check("rst_valid_op", valid_op, 0);
    check("rst_option", option, 0);
    check("rst_done", done, 0);
    check("rst_solved", solved, 0);
    check("rst_overflow", overflow, 0);
    check("rst_load_ready", load_ready, 1);

    // Reset while waiting on a verdict with five entries queued
    resp_en = 1'b0;
    push_exp(1, 0, 1); push_exp(0, 1, 1);
    load(1, 0);
    for (int k = 1; k <= 5; k++) load(0, SIZE'(k));
    pulse_start();
    repeat (6) @(negedge clk);
    check("t1_count_wait", count, 5);
    check("t1_valid_op_wait", valid_op, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_count", count, 0);
    check("t1_valid_op", valid_op, 0);
    check("t1_done", done, 0);
    check("t1_load_ready", load_ready, 1);
    check("t1_sb_empty", exp_q.size(), 0);
    resp_en = 1'b1;
    do_reset();

    // H0, A, B all kept: one pass, done, not solved
    push_exp(1, 0, 1); push_exp(0, 3'b101, 1); push_exp(0, 3'b011, 1);
    load(1, 0); load(0, 3'b101); load(0, 3'b011);
    pulse_start();
    wait_done("t2");
    check("t2_solved", solved, 0);
    check("t2_count", count, 3);
    start = 1'b1; load_valid = 1'b1; load_data = 3'd7;
    repeat (2) @(negedge clk);
    start = 1'b0; load_valid = 1'b0;
    check("t2_done_absorb_count", count, 3);
    check("t2_done_absorb_valid", valid_op, 0);
    do_reset();

    // A dropped on the first pass, second pass issues H0, B only
    push_exp(1, 0, 1); push_exp(0, 3'b101, 0); push_exp(0, 3'b011, 1);
    push_exp(1, 0, 1); push_exp(0, 3'b011, 1);
    load(1, 0); load(0, 3'b101);
    load_valid = 1'b1; load_is_line = 1'b0; load_data = 3'b011; start = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; start = 1'b0;
    wait_done("t3");
    check("t3_count", count, 2);
    check("t3_solved", solved, 0);
    do_reset();

    // Six lines with two options each; second option of every line rejected
    for (int i = 0; i < 6; i++) begin
      push_exp(1, SIZE'(i), 1); push_exp(0, SIZE'(i + 1), 1); push_exp(0, SIZE'(7 - i), 0);
    end
    for (int i = 0; i < 6; i++) begin
      push_exp(1, SIZE'(i), 1); push_exp(0, SIZE'(i + 1), 1);
    end
    for (int i = 0; i < 6; i++) begin
      load(1, SIZE'(i)); load(0, SIZE'(i + 1)); load(0, SIZE'(7 - i));
    end
    check("t4_count_loaded", count, 18);
    pulse_start();
    wait_done("t4");
    check("t4_solved", solved, 1);
    check("t4_count", count, 12);
    do_reset();

    // Depth-4 instance: fill past capacity
    for (int k = 0; k < 6; k++) begin
      b_load_valid = tbl[k].lv; b_load_is_line = tbl[k].il; b_load_data = tbl[k].d;
      check($sformatf("t5_ready_%0d", k), b_load_ready, tbl[k].exp_ready);
      @(negedge clk);
      check($sformatf("t5_count_%0d", k), b_count, tbl[k].exp_count);
      check($sformatf("t5_overflow_%0d", k), b_overflow, tbl[k].exp_ovf);
    end
    b_load_valid = 1'b0;
    do_reset();

    // Start on an empty queue
    pulse_start();
    check("t6_done", done, 1);
    check("t6_solved", solved, 0);
    check("t6_count", count, 0);
    repeat (5) @(negedge clk);
    check("t6_valid_op", valid_op, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
